// File: rtl/glyph_pixel_reader_pkg.sv
// Shared constants, fetch state encoding and glyph ROM address helper for the
// glyph pixel reader and its pixel shifter.
package glyph_pixel_reader_pkg;

    localparam int COLOR_W    = 12;
    localparam int GLYPH_W    = 16;
    localparam int GLYPH_ROWS = 16;
    localparam int CHAR_W     = 7;
    localparam int ROW_W      = 4;
    localparam int ROM_AW     = 11;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_FULL = 2'd2
    } fetch_state_e;

    // The ROM keeps glyph rows bottom-up, so the top row lives at the highest offset.
    function automatic logic [ROM_AW-1:0] glyph_addr(input logic [CHAR_W-1:0] chr,
                                                     input logic [ROW_W-1:0]  row);
        return {chr, ROW_W'(GLYPH_ROWS - 1) - row};
    endfunction

endpackage

// File: rtl/glyph_pixel_reader_if.sv
// Request (char/row/colours) and pixel stream handshakes of the glyph pixel reader.
// master = requester/pixel consumer, slave = the reader.
interface glyph_pixel_reader_if #(
    parameter int COLOR_W = 12
);
    logic               req_valid;
    logic               req_ready;
    logic [6:0]         req_char;
    logic [3:0]         req_row;
    logic [COLOR_W-1:0] req_fg;
    logic [COLOR_W-1:0] req_bg;

    logic               pix_valid;
    logic               pix_ready;
    logic [COLOR_W-1:0] pix_rgb;
    logic               pix_last;

    modport master (
        output req_valid, req_char, req_row, req_fg, req_bg, pix_ready,
        input  req_ready, pix_valid, pix_rgb, pix_last
    );

    modport slave (
        input  req_valid, req_char, req_row, req_fg, req_bg, pix_ready,
        output req_ready, pix_valid, pix_rgb, pix_last
    );

endinterface

// File: rtl/glyph_pixel_reader_shifter.sv
// Glyph row serialiser: shifts a row word out MSB-first as fg/bg pixels on a
// valid/ready stream and reports when it can accept the next row.
module glyph_pixel_reader_shifter #(
    parameter int COLOR_W = 12,
    parameter int GLYPH_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               load,
    input  logic [GLYPH_W-1:0] load_word,
    input  logic [COLOR_W-1:0] load_fg,
    input  logic [COLOR_W-1:0] load_bg,
    output logic               can_load,
    glyph_pixel_reader_if.slave bus
);
    import glyph_pixel_reader_pkg::*;

    localparam int CNT_W = $clog2(GLYPH_W);

    logic [GLYPH_W-1:0] shreg_r;
    logic [CNT_W-1:0]   pix_cnt_r;
    logic               valid_r;
    logic [COLOR_W-1:0] fg_r;
    logic [COLOR_W-1:0] bg_r;
    logic               hs_s;
    logic               last_s;

    // Handshake decode and output view of the shift register.
    always_comb begin
        hs_s          = valid_r & bus.pix_ready;
        last_s        = (pix_cnt_r == CNT_W'(GLYPH_W - 1));
        can_load      = ~valid_r | (hs_s & last_s);
        bus.pix_valid = valid_r;
        bus.pix_rgb   = shreg_r[GLYPH_W-1] ? fg_r : bg_r;
        bus.pix_last  = valid_r & last_s;
    end

    // Row load takes priority so a row arriving on the last-pixel handshake leaves no bubble.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shreg_r   <= {GLYPH_W{1'b0}};
            pix_cnt_r <= {CNT_W{1'b0}};
            valid_r   <= 1'b0;
            fg_r      <= {COLOR_W{1'b0}};
            bg_r      <= {COLOR_W{1'b0}};
        end else if (load) begin
            shreg_r   <= load_word;
            pix_cnt_r <= {CNT_W{1'b0}};
            valid_r   <= 1'b1;
            fg_r      <= load_fg;
            bg_r      <= load_bg;
        end else if (hs_s) begin
            shreg_r   <= shreg_r << 1;
            pix_cnt_r <= pix_cnt_r + CNT_W'(1);
            valid_r   <= ~last_s;
        end else begin
            shreg_r   <= shreg_r;
            pix_cnt_r <= pix_cnt_r;
            valid_r   <= valid_r;
        end
    end

endmodule

// File: rtl/glyph_pixel_reader.sv
// Glyph pixel reader: fetches one glyph row per request from the glyph ROM into a
// prefetch buffer and feeds it to the pixel shifter for gap-free scan-out.
module glyph_pixel_reader #(
    parameter int ROM_LAT = 1,
    parameter int COLOR_W = 12,
    parameter int GLYPH_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    glyph_pixel_reader_if.slave bus,
    output logic [10:0]        rom_addr,
    output logic               rom_en,
    input  logic [GLYPH_W-1:0] rom_do,
    output logic               busy
);
    import glyph_pixel_reader_pkg::*;

    localparam logic [1:0] LAT_INIT = 2'(ROM_LAT - 1);

    fetch_state_e       state_r;
    fetch_state_e       state_nxt_s;
    logic               req_ready_r;
    logic [10:0]        addr_r;
    logic [10:0]        addr_new_s;
    logic [1:0]         lat_cnt_r;
    logic [GLYPH_W-1:0] buf_word_r;
    logic [GLYPH_W-1:0] buf_word_s;
    logic [COLOR_W-1:0] fg_r;
    logic [COLOR_W-1:0] bg_r;
    logic               hs_s;
    logic               buf_full_s;
    logic               can_load_s;
    logic               load_s;

    // Fetch FSM next state; the buffer is bypassed from rom_do in the capture cycle.
    always_comb begin
        hs_s          = bus.req_valid & req_ready_r;
        addr_new_s    = glyph_addr(bus.req_char, bus.req_row);
        state_nxt_s   = state_r;
        rom_en        = 1'b0;
        rom_addr      = addr_r;
        buf_full_s    = 1'b0;
        buf_word_s    = buf_word_r;
        case (state_r)
            F_IDLE: begin
                if (hs_s) begin
                    rom_en      = 1'b1;
                    rom_addr    = addr_new_s;
                    state_nxt_s = F_WAIT;
                end else begin
                    state_nxt_s = F_IDLE;
                end
            end
            F_WAIT: begin
                if (lat_cnt_r == 2'd0) begin
                    buf_full_s  = 1'b1;
                    buf_word_s  = rom_do;
                    state_nxt_s = can_load_s ? F_IDLE : F_FULL;
                end else begin
                    state_nxt_s = F_WAIT;
                end
            end
            F_FULL: begin
                buf_full_s  = 1'b1;
                state_nxt_s = can_load_s ? F_IDLE : F_FULL;
            end
            default: begin
                state_nxt_s = F_IDLE;
            end
        endcase
        load_s        = buf_full_s & can_load_s;
        busy          = (state_r != F_IDLE) | bus.pix_valid;
        bus.req_ready = req_ready_r;
    end

    // Fetch state, registered ready, address hold, latency count and prefetch buffer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= F_IDLE;
            req_ready_r <= 1'b1;
            addr_r      <= 11'd0;
            lat_cnt_r   <= 2'd0;
            buf_word_r  <= {GLYPH_W{1'b0}};
            fg_r        <= {COLOR_W{1'b0}};
            bg_r        <= {COLOR_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == F_IDLE);
            buf_word_r  <= buf_word_s;
            if (hs_s) begin
                addr_r    <= addr_new_s;
                fg_r      <= bus.req_fg;
                bg_r      <= bus.req_bg;
                lat_cnt_r <= LAT_INIT;
            end else if ((state_r == F_WAIT) && (lat_cnt_r != 2'd0)) begin
                lat_cnt_r <= lat_cnt_r - 2'd1;
            end else begin
                lat_cnt_r <= lat_cnt_r;
            end
        end
    end

    glyph_pixel_reader_shifter #(
        .COLOR_W (COLOR_W),
        .GLYPH_W (GLYPH_W)
    ) u_shifter (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load_s),
        .load_word (buf_word_s),
        .load_fg   (fg_r),
        .load_bg   (bg_r),
        .can_load  (can_load_s),
        .bus       (bus)
    );

endmodule
